// File: rtl/reg_dump_unit.sv
// Debug read-out engine: sweeps register-file port 1 addresses 0..NREG-1 and
// streams each captured word over valid/ready, holding the core halted throughout.
module reg_dump_unit #(
  parameter int W    = 32,
  parameter int NREG = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] RD1,
  output logic [3:0]   rd_addr,
  output logic         dbg_sel,
  output logic         halt_req,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [3:0]   out_index,
  output logic         out_last,
  output logic         done
);

  typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;

  localparam logic [3:0] LAST_IDX = 4'(NREG - 1);

  state_t         state_q, state_d;
  logic [3:0]     idx_q, idx_d;
  logic [W-1:0]   data_q, data_d;
  logic [3:0]     index_q, index_d;
  logic           valid_q, valid_d;
  logic           last_q, last_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      data_q  <= '0;
      index_q <= 4'd0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      index_q <= index_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    index_d = index_q;
    valid_d = valid_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = READ;
          idx_d   = 4'd0;
        end
      end
      READ: begin
        data_d  = RD1;
        index_d = idx_q;
        valid_d = 1'b1;
        last_d  = (idx_q == LAST_IDX);
        state_d = SEND;
      end
      SEND: begin
        // Terminal check precedes increment so idx never wraps.
        if (out_ready) begin
          valid_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = READ;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rd_addr   = idx_q;
  assign dbg_sel   = (state_q != IDLE);
  assign halt_req  = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_index = index_q;
  assign out_last  = last_q;

endmodule

// File: tb/tb_reg_dump_unit.sv
// Directed bench for reg_dump_unit: reset, full sweep, backpressure, start while
// busy, reset mid-sweep, and a NREG=4 instance.
module tb_reg_dump_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic        out_ready;
  logic [31:0] rd1;
  logic [3:0]  rd_addr;
  logic        dbg_sel, halt_req, out_valid, out_last, done;
  logic [31:0] out_data;
  logic [3:0]  out_index;

  logic        start4;
  logic        ready4;
  logic [31:0] rd1_4;
  logic [3:0]  rd_addr4;
  logic        dbg_sel4, halt_req4, out_valid4, out_last4, done4;
  logic [31:0] out_data4;
  logic [3:0]  out_index4;

  int compared;
  int mismatched;

  // Register-file model: Rk = 0xA5A50000 + k
  assign rd1   = 32'hA5A5_0000 + {28'd0, rd_addr};
  assign rd1_4 = 32'hA5A5_0000 + {28'd0, rd_addr4};

  reg_dump_unit #(.W(32), .NREG(16)) dut (
    .clk(clk), .reset(reset), .start(start), .RD1(rd1),
    .rd_addr(rd_addr), .dbg_sel(dbg_sel), .halt_req(halt_req),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .done(done)
  );

  reg_dump_unit #(.W(32), .NREG(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .RD1(rd1_4),
    .rd_addr(rd_addr4), .dbg_sel(dbg_sel4), .halt_req(halt_req4),
    .out_valid(out_valid4), .out_ready(ready4), .out_data(out_data4),
    .out_index(out_index4), .out_last(out_last4), .done(done4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_rd_addr"},   {28'd0, rd_addr},   32'd0);
    check({tag, "_dbg_sel"},   {31'd0, dbg_sel},   32'd0);
    check({tag, "_halt_req"},  {31'd0, halt_req},  32'd0);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_out_data"},  out_data,           32'd0);
    check({tag, "_out_index"}, {28'd0, out_index}, 32'd0);
    check({tag, "_out_last"},  {31'd0, out_last},  32'd0);
    check({tag, "_done"},      {31'd0, done},      32'd0);
  endtask

  initial begin
    int words;
    int dones;
    int exp_idx;
    compared   = 0;
    mismatched = 0;
    reset      = 1'b0;
    start      = 1'b1;
    out_ready  = 1'b1;
    start4     = 1'b0;
    ready4     = 1'b1;

    // Reset held two cycles with start high: everything stays zero
    tick();
    check_idle("rst1");
    tick();
    check_idle("rst2");
    check("rst_u4_valid", {31'd0, out_valid4}, 32'd0);
    start = 1'b0;
    reset = 1'b1;
    tick();
    check_idle("post_rst");

    // Full sweep with out_ready=1; done 33 cycles after the start edge
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      check("sweep_rd_addr", {28'd0, rd_addr}, k);
      check("sweep_halt_read", {31'd0, halt_req}, 32'd1);
      check("sweep_valid_read", {31'd0, out_valid}, 32'd0);
      tick();
      check("sweep_valid", {31'd0, out_valid}, 32'd1);
      check("sweep_index", {28'd0, out_index}, k);
      check("sweep_data", out_data, 32'hA5A5_0000 + k);
      check("sweep_last", {31'd0, out_last}, (k == 15) ? 32'd1 : 32'd0);
      check("sweep_done_early", {31'd0, done}, 32'd0);
      tick();
    end
    check("sweep_done", {31'd0, done}, 32'd1);
    check("sweep_halt_done", {31'd0, halt_req}, 32'd1);
    tick();
    check("sweep_done_clear", {31'd0, done}, 32'd0);
    check("sweep_idle_halt", {31'd0, halt_req}, 32'd0);

    // Backpressure on index 3 for five cycles
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    check("bp_read3_addr", {28'd0, rd_addr}, 32'd3);
    out_ready = 1'b0;
    tick();
    for (int c = 0; c < 5; c++) begin
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_data", out_data, 32'hA5A5_0003);
      check("bp_index", {28'd0, out_index}, 32'd3);
      check("bp_rd_addr", {28'd0, rd_addr}, 32'd3);
      tick();
    end
    out_ready = 1'b1;
    check("bp_release_index", {28'd0, out_index}, 32'd3);
    tick();
    check("bp_after_valid", {31'd0, out_valid}, 32'd0);
    check("bp_after_addr", {28'd0, rd_addr}, 32'd4);
    tick();
    check("bp_next_index", {28'd0, out_index}, 32'd4);
    check("bp_next_data", out_data, 32'hA5A5_0004);
    for (int i = 0; i < 60 && !done; i++) tick();
    check("bp_done", {31'd0, done}, 32'd1);
    tick();

    // Start pulses while busy are ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    words = 0;
    dones = 0;
    exp_idx = 0;
    for (int c = 0; c < 60; c++) begin
      if (out_valid && out_ready) begin
        check("busy_index", {28'd0, out_index}, exp_idx);
        exp_idx++;
        words++;
      end
      if (done) dones++;
      start = out_valid && (out_index == 4'd2 || out_index == 4'd9);
      tick();
    end
    start = 1'b0;
    check("busy_words", words, 32'd16);
    check("busy_dones", dones, 32'd1);
    check("busy_idle", {31'd0, halt_req}, 32'd0);

    // Reset in SEND at index 7 abandons the sweep
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (14) tick();
    tick();
    check("mid_valid", {31'd0, out_valid}, 32'd1);
    check("mid_index", {28'd0, out_index}, 32'd7);
    reset = 1'b0;
    tick();
    check_idle("mid_rst");
    reset = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_addr", {28'd0, rd_addr}, 32'd0);
    check("restart_dbg", {31'd0, dbg_sel}, 32'd1);
    tick();
    check("restart_index", {28'd0, out_index}, 32'd0);
    check("restart_data", out_data, 32'hA5A5_0000);
    for (int i = 0; i < 60 && !done; i++) tick();
    check("restart_done", {31'd0, done}, 32'd1);
    tick();

    // NREG=4 instance: done 9 cycles after start edge
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("n4_rd_addr", {28'd0, rd_addr4}, k);
      tick();
      check("n4_index", {28'd0, out_index4}, k);
      check("n4_data", out_data4, 32'hA5A5_0000 + k);
      check("n4_last", {31'd0, out_last4}, (k == 3) ? 32'd1 : 32'd0);
      tick();
    end
    check("n4_done", {31'd0, done4}, 32'd1);
    tick();
    check("n4_done_clear", {31'd0, done4}, 32'd0);
    check("n4_idle", {31'd0, halt_req4}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
